// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry layout, NOP encoding.
package fetch_pkg;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fetch_entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO in front of decode; flush empties it and may load one entry in the same edge.
module fetch_queue #(
  parameter int W     = 65,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // a flush can carry a single replacement entry (the misaligned marker)
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
      if (push) mem[0] <= push_data;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, busywait imem requests, decoupling queue to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets become a queue marker and halt fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH  = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_readdata,
  input  logic            imem_busywait,
  input  logic            dmem_busywait,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misaligned
);
  localparam int EW = 2 * XLEN + 1;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] next_pc, req_addr, tgt;
  logic            tgt_mis, next_mis, in_flight, done, push, pop;
  logic [EW-1:0]   push_data, head;
  logic [CW-1:0]   count;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt      = redirect_pc;
  assign tgt_mis  = |redirect_pc[1:0];
  assign next_mis = |next_pc[1:0];
`else
  assign tgt      = redirect_pc & ~XLEN'(3);
  assign tgt_mis  = 1'b0;
  assign next_mis = 1'b0;
`endif

  // reset gates the request combinationally so an abandoned request drops at once
  assign imem_read    = RESET && ((state == S_FETCH && count < CW'(QUEUE_DEPTH)) ||
                                  state == S_DRAIN);
  assign imem_address = req_addr;
  assign in_flight    = imem_read & imem_busywait;
  assign done         = imem_read & ~imem_busywait;

  assign push      = redirect_valid ? tgt_mis : (done && state == S_FETCH);
  assign push_data = redirect_valid ? {tgt, {XLEN{1'b0}}, 1'b1}
                                    : {req_addr, imem_readdata, 1'b0};
  assign pop       = if_valid & id_ready & ~dmem_busywait & ~redirect_valid;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_FETCH;
      next_pc  <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
    end else if (redirect_valid) begin
      next_pc <= tgt;
      if (in_flight) begin
        state <= S_DRAIN;
      end else begin
        req_addr <= tgt;
        state    <= tgt_mis ? S_HALT : S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH: if (done) begin
          next_pc  <= next_pc + XLEN'(4);
          req_addr <= next_pc + XLEN'(4);
        end
        // held address completes with stale data; then switch to the redirect target
        S_DRAIN: if (done) begin
          req_addr <= next_pc;
          state    <= next_mis ? S_HALT : S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  fetch_queue #(.W(EW), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (CLK),
    .rst_n     (RESET),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign if_valid      = (count != '0);
  assign if_pc         = if_valid ? head[EW-1 -: XLEN] : '0;
  assign if_pc_plus4   = if_valid ? head[EW-1 -: XLEN] + XLEN'(4) : '0;
  assign if_instr      = if_valid ? head[XLEN:1] : '0;
  assign if_misaligned = if_valid & head[0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random stimulus against a transaction model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        CLK, RESET;
  logic        imem_read, imem_busywait, dmem_busywait, redirect_valid, id_ready;
  logic [31:0] imem_address, imem_readdata, redirect_pc;
  logic        if_valid, if_misaligned;
  logic [31:0] if_pc, if_pc_plus4, if_instr;

  int errors = 0;
  int checks = 0;

  // model state: what decode should see and what memory should be asked for
  fetch_entry_t q[$];
  logic [31:0]  fetch_pc   = 32'h0;
  logic [31:0]  drain_addr = 32'h0;
  bit           draining   = 0;
  bit           halted     = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_readdata  (imem_readdata),
    .imem_busywait  (imem_busywait),
    .dmem_busywait  (dmem_busywait),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .if_misaligned  (if_misaligned)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_readdata = imem_busywait ? 32'hDEAD_BEEF : memf(imem_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_read();
    return draining || (!halted && q.size() < DEPTH);
  endfunction

  // drive one cycle of inputs, check outputs, then advance the model across the edge
  task automatic step(input bit rv, input logic [31:0] rpc, input bit bw, input bit dbw,
                      input bit idr);
    bit rd, done, infl, deq, mis;
    logic [31:0] tgt;
    redirect_valid = rv; redirect_pc = rpc; imem_busywait = bw;
    dmem_busywait = dbw; id_ready = idr;
    #1;
    rd = exp_read();
    chk("imem_read", {31'd0, imem_read}, {31'd0, rd});
    if (rd) chk("imem_address", imem_address, draining ? drain_addr : fetch_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_pc_plus4", if_pc_plus4, q[0].pc + 32'd4);
      chk("if_instr", if_instr, q[0].instr);
      chk("if_misaligned", {31'd0, if_misaligned}, {31'd0, q[0].misaligned});
    end
    done = rd && !bw;
    infl = rd && bw;
    deq  = q.size() > 0 && idr && !dbw;
    if (rv) begin
      tgt = rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis = (rpc[1:0] != 2'b00);
`else
      mis = 0;
      tgt[1:0] = 2'b00;
`endif
      q.delete();
      if (mis) q.push_back('{pc: tgt, instr: 32'h0, misaligned: 1'b1});
      if (infl) begin
        if (!draining) drain_addr = fetch_pc;
        draining = 1;
      end else draining = 0;
      fetch_pc = tgt;
      halted   = mis;
    end else begin
      if (deq) void'(q.pop_front());
      if (done) begin
        if (draining) draining = 0;
        else begin
          q.push_back('{pc: fetch_pc, instr: memf(fetch_pc), misaligned: 1'b0});
          fetch_pc = fetch_pc + 32'd4;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0;
    redirect_valid = 0; redirect_pc = 0; imem_busywait = 0;
    dmem_busywait = 0; id_ready = 0;
    repeat (3) @(negedge CLK);
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_misaligned", {31'd0, if_misaligned}, 32'd0);
    RESET = 1'b1;

    // sequential fetch, zero-wait, decode always ready
    repeat (2) step(0, 0, 0, 0, 1);
    // stall on address 8, redirect to 0x100 while waiting
    step(0, 0, 1, 0, 1);
    step(1, 32'h100, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    // decode stalled: queue fills and requests stop
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1);
    // redirect coincident with a completion
    step(1, 32'h40, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    // data-memory stall blocks dequeue
    repeat (4) step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    // misaligned target
    step(1, 32'h102, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0);
    step(1, 32'h200, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    // PC wrap at the top of the address space
    step(1, 32'hFFFF_FFF8, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 5) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 40) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    // reset asserted mid-request drops the read immediately
    step(1, 32'h80, 0, 0, 1);
    redirect_valid = 0; imem_busywait = 1;
    #1;
    chk("pre_rst_read", {31'd0, imem_read}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("async_rst_read", {31'd0, imem_read}, 32'd0);
    chk("async_rst_valid", {31'd0, if_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetch stage with a decoupling queue. It generates sequential and redirected PCs and issues reads to instruction memory over the busywait protocol. Completed fetches are buffered in a small FIFO in front of decode, so fetch continues while decode or data memory stalls. It sits between instruction memory/cache and the IF/ID boundary, and takes redirects from the branch/jump resolution in execute.

## Interface
- XLEN, 32, address and instruction width
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- QUEUE_DEPTH, 2, fetch queue entries; power of two, ≥2

- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- imem_read  out  1  read request
- imem_address  out  XLEN  request address; stable while imem_read=1 and imem_busywait=1
- imem_readdata  in  XLEN  instruction; valid in the completing cycle
- imem_busywait  in  1  memory not ready
- dmem_busywait  in  1  data-memory stall; blocks dequeue
- redirect_valid  in  1  branch/jump taken, flush
- redirect_pc  in  XLEN  redirect target
- id_ready  in  1  decode accepts head entry
- if_valid  out  1  head entry valid
- if_pc  out  XLEN  PC of head entry
- if_pc_plus4  out  XLEN  if_pc+4, mod 2^XLEN
- if_instr  out  XLEN  instruction of head entry
- if_misaligned  out  1  head entry is a misaligned-target marker (0 when macro off)

## Operation
- Registers: next_pc, req_addr (drives imem_address), FSM state, queue, count.
- Transfer completes at an edge where imem_read=1 and imem_busywait=0.
- Dequeue at an edge where if_valid & id_ready & !dmem_busywait.
- FSM states:
  - S_FETCH: imem_read = (count<QUEUE_DEPTH); req_addr=next_pc. On completion: enqueue {req_addr, readdata}, next_pc+=4. If queue full, imem_read=0 and stay.
  - S_DRAIN: entered on redirect while a request is in flight (imem_read=1, busywait=1). imem_read stays 1, req_addr is held, and the returned data is discarded. Return to S_FETCH on completion.
  - S_HALT: macro only; entered after a misaligned marker is enqueued. No requests. Leave on redirect.
- Redirect handling: queue flushed (count=0), next_pc=redirect_pc. Go to S_DRAIN if a request is in flight, else S_FETCH.
- Priorities at the same edge: redirect > completion > dequeue. A completion coincident with a redirect is dropped. A dequeue coincident with a redirect is lost, which is correct because decode is flushed too.
- PC arithmetic wraps modulo 2^XLEN with no flag.
- Simultaneous enqueue and dequeue with a full queue: both allowed only when count<QUEUE_DEPTH at issue; count unchanged.
- Reset mid-request: imem_read drops immediately (asynchronous); memory must tolerate an abandoned request.

## Timing
- Reset values: imem_read=0 during reset, imem_address=RESET_VECTOR, if_valid=0, if_*=0, count=0, state=S_FETCH, next_pc=RESET_VECTOR.
- First imem_read=1 in the first cycle after RESET deasserts.
- Zero-wait memory: fetch issued in cycle N, enqueued at edge N, if_valid in cycle N+1. No bypass.
- Sustained throughput: 1 instr/cycle with zero-wait memory and id_ready=1.
- Redirect sampled at edge R, no in-flight request: new address on imem_address in cycle R+1. First redirected instruction on if_* in cycle R+2 at the earliest.
- Redirect with in-flight request: new address issued the cycle after the drain completes.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect_pc with bits[1:0]≠0 issues no memory request.
  - It enqueues one entry {pc=redirect_pc, instr=0, misaligned=1} and enters S_HALT.
- FETCH_MISALIGN_TRAP_EN undefined:
  - redirect_pc[1:0] is forced to 00.
  - if_misaligned is tied to 0 and S_HALT is unreachable.

## Structure
- Package fetch_pkg:
  - state enum (S_FETCH, S_DRAIN, S_HALT)
  - fetch entry struct {pc, instr, misaligned}
  - NOP encoding 32'h0000_0013
- Sub-module fetch_queue: synchronous FIFO parametrised by entry width and depth, with flush input, count output and registered head.

## Test plan
- Reset release, zero-wait memory, id_ready=1 -> addresses 0,4,8,… on consecutive cycles; if_pc=0 in cycle 2; if_pc_plus4=4.
- id_ready=0 for 5 cycles, QUEUE_DEPTH=2 -> imem_read drops after 2 completions; on release, if_pc 0,4,8 in order with no loss or duplication.
- imem_busywait high 3 cycles on address 8, redirect_pc=0x100 during wait -> imem_address stays 8 until completion; data discarded; next request 0x100; if_pc sequence resumes at 0x100.
- redirect and completion on the same edge, redirect_pc=0x40 -> completed instruction never appears; next if_pc=0x40.
- dmem_busywait=1 with id_ready=1 -> no dequeue; queue fills; head if_pc unchanged until dmem_busywait=0.
- Macro on, redirect_pc=0x102 -> if_valid=1, if_misaligned=1, if_pc=0x102, imem_read=0 until next redirect to 0x200. Macro off -> fetch from 0x100.
